pipe3_acc: RTL and testbench
============================

# pipe3_acc

Parametrised three-stage (fetch / decode / execute) instruction pipeline with an accumulator datapath. It generalises the fixed 4-bit fetch/decode/execute block to a WIDTH-bit instruction word and adds valid tracking, stall, flush and retire counting. It sits between the instruction source (`next`) and downstream observers of `ir`, `id` and `iex`.

## Interface
- WIDTH, 8, instruction and accumulator width in bits; must be ≥ 4. Opcode is `[WIDTH-1:WIDTH-2]` and the immediate is `[WIDTH-3:0]`.
- RET_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- next  in  WIDTH  instruction to fetch.
- next_valid  in  1  `next` is valid this cycle.
- stall  in  1  hold the IF and ID stages; insert a bubble into EX.
- flush  in  1  kill the IF and ID contents.
- ir  out  WIDTH  IF-stage instruction register.
- ir_valid  out  1  `ir` holds a live instruction.
- id  out  1  ID stage holds a valid, non-NOP instruction.
- id_op  out  2  ID-stage opcode.
- iex  out  WIDTH  accumulator (execute result).
- zero  out  1  `iex == 0`; registered together with `iex`.
- retired  out  RET_W  count of non-NOP instructions executed; wraps.

## Operation
Opcodes:
- 00 NOP
- 01 LOAD: acc = zero-extended imm
- 10 ADD: acc = acc + imm
- 11 SUB: acc = acc − imm

Arithmetic is modulo 2^WIDTH. Carry and borrow are discarded.

Stage registers:
- IF: `ir`, `ir_valid`.
- ID: `id_op`, `id_imm`, `id_valid`. Output `id = id_valid && id_op != 00`.
- EX: `iex`, `zero`, `retired`.

Each edge, with no stall and no flush:
- IF ← (`next`, `next_valid`).
- ID ← decode(`ir`), `id_valid` ← `ir_valid`.
- EX executes the ID contents if `id_valid`.
- `retired` += 1 when the executed op is not NOP.

Stall (`stall=1`, `flush=0`):
- IF and ID hold their contents; `next` is not captured.
- EX sees a bubble: `iex`, `zero` and `retired` are unchanged.

Flush (`flush=1`):
- `ir_valid` ← 0 and `id_valid` ← 0.
- The ID contents present on the flush edge are not executed.
- `ir` and `id_op` data bits may hold their old values; only the valid bits are specified.
- Flush has priority over stall when both are asserted.

Other rules:
- `next_valid=0` inserts a bubble into IF.
- An `ir_valid` instruction equal to 0 is a NOP: it flows through the pipeline but does not count toward `retired`.

Reset (`rst_n` low, asynchronous, at any time including mid-pipeline):
- `ir=0`, `ir_valid=0`, `id_op=00`, `id_valid=0`, `id=0`, `iex=0`, `zero=1`, `retired=0`.
- All in-flight instructions are discarded.
- The first capture happens on the first rising edge after `rst_n` deasserts.

## Timing
- Instruction presented at edge E0 → visible on `ir` after E0 → on `id`/`id_op` after E0+1 → result on `iex`/`zero`/`retired` after E0+2. Latency is 3 edges from capture to result.
- Throughput is one instruction per cycle without stall.
- No forwarding is needed: the accumulator lives only in EX, so back-to-back dependent ops are correct.
- Stall of N cycles delays all in-flight results by exactly N cycles. The instruction held in ID executes on the first edge after `stall` falls.
- Flush at edge F loses the instructions in IF and ID at F. The instruction captured at F+1 is the next one executed, with its result after F+3.
- `retired` wraps from 2^RET_W−1 to 0.

## Test plan
All scenarios use WIDTH=8.
1. Reset: hold `rst_n=0` for 2 cycles with `next=0x45`, `next_valid=1` → all outputs at reset values (`iex=0`, `zero=1`, `retired=0`).
2. Stream 0x45, 0x83, 0xCA on consecutive edges → `iex` = 5, 8, 0xFE after edges 3, 4, 5; `zero=0`; `retired=3`; `id=1` on cycles 2–4.
3. Wrap: 0x7F followed by four 0xBF → `iex` = 63, 126, 189, 252, 59; then 0xC0|59 (0xFB) → `iex=0`, `zero=1`.
4. Stall: stream 0x41, 0x81, 0x81 with `stall=1` for 2 cycles starting one edge after the first capture → `iex` progression 1, 2, 3 delayed by 2 cycles; `iex` and `retired` frozen during the stall.
5. Flush: stream 0x45, 0x83, 0x8A, asserting `flush` on the edge after 0x8A is captured → only LOAD 5 executes, `iex=5`, `retired=1`; flush+stall together behaves as flush.
6. NOPs and async reset: 0x00 and `next_valid=0` bubbles → `retired` unchanged; drop `rst_n` between clock edges mid-stream → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe3_acc.sv
// Three-stage fetch/decode/execute pipeline driving a WIDTH-bit accumulator.
// Valid bits travel with each instruction. Stall freezes IF/ID and bubbles EX; flush kills IF/ID.
module pipe3_acc #(
    parameter int WIDTH = 8,
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] next,
    input  logic             next_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] ir,
    output logic             ir_valid,
    output logic             id,
    output logic [1:0]       id_op,
    output logic [WIDTH-1:0] iex,
    output logic             zero,
    output logic [RET_W-1:0] retired
);

    localparam int IMM_W = WIDTH - 2;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    // Accumulator update for one executed instruction; carry/borrow are dropped.
    function automatic logic [WIDTH-1:0] alu(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] acc,
        input logic [IMM_W-1:0] imm
    );
        logic [WIDTH-1:0] ext;
        ext = {2'b00, imm};
        case (op)
            OP_LOAD: alu = ext;
            OP_ADD:  alu = acc + ext;
            OP_SUB:  alu = acc - ext;
            OP_NOP:  alu = acc;
            default: alu = acc;
        endcase
    endfunction

    logic [WIDTH-1:0] ir_r,       ir_s;
    logic             ir_valid_r, ir_valid_s;
    logic [1:0]       id_op_r,    id_op_s;
    logic [IMM_W-1:0] id_imm_r,   id_imm_s;
    logic             id_valid_r, id_valid_s;
    logic             id_r,       id_s;
    logic [WIDTH-1:0] iex_r,      iex_s;
    logic             zero_r,     zero_s;
    logic [RET_W-1:0] retired_r,  retired_s;

    // Next-state for all three stages; flush outranks stall.
    always_comb begin
        ir_s       = ir_r;
        ir_valid_s = ir_valid_r;
        id_op_s    = id_op_r;
        id_imm_s   = id_imm_r;
        id_valid_s = id_valid_r;
        id_s       = id_r;
        iex_s      = iex_r;
        zero_s     = zero_r;
        retired_s  = retired_r;

        if (flush) begin
            // Data bits are left alone; only the valid bits are cleared.
            ir_valid_s = 1'b0;
            id_valid_s = 1'b0;
            id_s       = 1'b0;
        end else if (stall) begin
            ir_valid_s = ir_valid_r;
            id_valid_s = id_valid_r;
        end else begin
            ir_s       = next;
            ir_valid_s = next_valid;
            id_op_s    = ir_r[WIDTH-1 -: 2];
            id_imm_s   = ir_r[IMM_W-1:0];
            id_valid_s = ir_valid_r;
            id_s       = ir_valid_r && (ir_r[WIDTH-1 -: 2] != OP_NOP);

            if (id_valid_r) begin
                iex_s  = alu(id_op_r, iex_r, id_imm_r);
                zero_s = (iex_s == {WIDTH{1'b0}});
                if (id_op_r != OP_NOP) begin
                    retired_s = retired_r + {{(RET_W-1){1'b0}}, 1'b1};
                end else begin
                    retired_s = retired_r;
                end
            end else begin
                iex_s  = iex_r;
                zero_s = zero_r;
            end
        end
    end

    // Stage registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r       <= {WIDTH{1'b0}};
            ir_valid_r <= 1'b0;
            id_op_r    <= OP_NOP;
            id_imm_r   <= {IMM_W{1'b0}};
            id_valid_r <= 1'b0;
            id_r       <= 1'b0;
            iex_r      <= {WIDTH{1'b0}};
            zero_r     <= 1'b1;
            retired_r  <= {RET_W{1'b0}};
        end else begin
            ir_r       <= ir_s;
            ir_valid_r <= ir_valid_s;
            id_op_r    <= id_op_s;
            id_imm_r   <= id_imm_s;
            id_valid_r <= id_valid_s;
            id_r       <= id_s;
            iex_r      <= iex_s;
            zero_r     <= zero_s;
            retired_r  <= retired_s;
        end
    end

    assign ir       = ir_r;
    assign ir_valid = ir_valid_r;
    assign id       = id_r;
    assign id_op    = id_op_r;
    assign iex      = iex_r;
    assign zero     = zero_r;
    assign retired  = retired_r;

endmodule

// File: tb/tb_pipe3_acc.sv
// Directed bench for pipe3_acc: captured instructions queue up in a scoreboard and are
// popped and executed on an architectural accumulator when they leave ID.
module tb_pipe3_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  next;
    logic        next_valid;
    logic        stall;
    logic        flush;
    logic [7:0]  ir;
    logic        ir_valid;
    logic        id;
    logic [1:0]  id_op;
    logic [7:0]  iex;
    logic        zero;
    logic [15:0] retired;

    int tests = 0;
    int fails = 0;

    logic [7:0]  sb[$];
    logic        m_if_v;
    logic        m_id_v;
    logic [7:0]  m_acc;
    logic [15:0] m_ret;

    pipe3_acc #(.WIDTH(8), .RET_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .next(next), .next_valid(next_valid),
        .stall(stall), .flush(flush), .ir(ir), .ir_valid(ir_valid), .id(id),
        .id_op(id_op), .iex(iex), .zero(zero), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_if_v = 1'b0;
        m_id_v = 1'b0;
        m_acc  = 8'h00;
        m_ret  = 16'h0000;
    endtask

    task automatic exec(input logic [7:0] ins);
        logic [7:0] imm;
        imm = {2'b00, ins[5:0]};
        case (ins[7:6])
            2'b01:   m_acc = imm;
            2'b10:   m_acc = m_acc + imm;
            2'b11:   m_acc = m_acc - imm;
            default: m_acc = m_acc;
        endcase
        if (ins[7:6] != 2'b00) m_ret = m_ret + 16'd1;
    endtask

    task automatic check_all();
        logic exp_id;
        exp_id = m_id_v ? (sb[0][7:6] != 2'b00) : 1'b0;
        chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_if_v});
        if (m_if_v) chk("ir", {24'd0, ir}, {24'd0, sb[sb.size()-1]});
        chk("id", {31'd0, id}, {31'd0, exp_id});
        if (m_id_v) chk("id_op", {30'd0, id_op}, {30'd0, sb[0][7:6]});
        chk("iex", {24'd0, iex}, {24'd0, m_acc});
        chk("zero", {31'd0, zero}, {31'd0, (m_acc == 8'h00)});
        chk("retired", {16'd0, retired}, {16'd0, m_ret});
    endtask

    // One clock edge with the given inputs, then model update and comparison.
    task automatic step(input logic [7:0] n, input logic nv, input logic st, input logic fl);
        logic [7:0] ins;
        next = n; next_valid = nv; stall = st; flush = fl;
        @(posedge clk);
        if (fl) begin
            sb.delete();
            m_if_v = 1'b0;
            m_id_v = 1'b0;
        end else if (!st) begin
            if (m_id_v) begin
                ins = sb.pop_front();
                exec(ins);
            end
            m_id_v = m_if_v;
            m_if_v = nv;
            if (nv) sb.push_back(n);
        end
        #1;
        check_all();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ir"}, {24'd0, ir}, 32'd0);
        chk({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd0);
        chk({tag, "_id"}, {31'd0, id}, 32'd0);
        chk({tag, "_id_op"}, {30'd0, id_op}, 32'd0);
        chk({tag, "_iex"}, {24'd0, iex}, 32'd0);
        chk({tag, "_zero"}, {31'd0, zero}, 32'd1);
        chk({tag, "_retired"}, {16'd0, retired}, 32'd0);
    endtask

    initial begin
        // 1. reset with a valid instruction presented
        rst_n = 1'b0; next = 8'h45; next_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 2. stream LOAD 5, ADD 3, SUB 10
        step(8'h45, 1'b1, 1'b0, 1'b0);
        step(8'h83, 1'b1, 1'b0, 1'b0);
        chk("s2_id_cycle2", {31'd0, id}, 32'd1);
        step(8'hCA, 1'b1, 1'b0, 1'b0);
        chk("s2_iex_e3", {24'd0, iex}, 32'h05);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("s2_iex_e4", {24'd0, iex}, 32'h08);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("s2_iex_e5", {24'd0, iex}, 32'hFE);
        chk("s2_zero", {31'd0, zero}, 32'd0);
        chk("s2_retired", {16'd0, retired}, 32'd3);

        // 3. modulo wrap then subtract to zero
        step(8'h7F, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'hBF, 1'b1, 1'b0, 1'b0);
        step(8'hFB, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("s3_iex_wrap", {24'd0, iex}, 32'd59);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("s3_iex_zero", {24'd0, iex}, 32'd0);
        chk("s3_zero", {31'd0, zero}, 32'd1);
        chk("s3_retired", {16'd0, retired}, 32'd9);

        // 4. two-cycle stall one edge after the first capture
        step(8'h41, 1'b1, 1'b0, 1'b0);
        step(8'h81, 1'b1, 1'b1, 1'b0);
        chk("s4_frozen_iex", {24'd0, iex}, 32'd0);
        step(8'h81, 1'b1, 1'b1, 1'b0);
        chk("s4_frozen_ret", {16'd0, retired}, 32'd9);
        step(8'h81, 1'b1, 1'b0, 1'b0);
        step(8'h81, 1'b1, 1'b0, 1'b0);
        chk("s4_iex_1", {24'd0, iex}, 32'd1);
        for (int i = 0; i < 2; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("s4_iex_3", {24'd0, iex}, 32'd3);
        chk("s4_retired", {16'd0, retired}, 32'd12);

        // 5. flush, then flush together with stall
        step(8'h45, 1'b1, 1'b0, 1'b0);
        step(8'h83, 1'b1, 1'b0, 1'b0);
        step(8'h8A, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("s5_iex", {24'd0, iex}, 32'd5);
        chk("s5_retired", {16'd0, retired}, 32'd13);
        step(8'h41, 1'b1, 1'b0, 1'b0);
        step(8'h81, 1'b1, 1'b0, 1'b0);
        step(8'h81, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b1);
        chk("s5_fs_ir_valid", {31'd0, ir_valid}, 32'd0);
        step(8'h83, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("s5_fs_iex", {24'd0, iex}, 32'd4);
        chk("s5_fs_retired", {16'd0, retired}, 32'd15);

        // 6. NOP and bubbles, then asynchronous reset mid-stream
        step(8'h00, 1'b1, 1'b0, 1'b0);
        step(8'h45, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("s6_nop_retired", {16'd0, retired}, 32'd15);
        chk("s6_nop_iex", {24'd0, iex}, 32'd4);
        step(8'h45, 1'b1, 1'b0, 1'b0);
        step(8'h83, 1'b1, 1'b0, 1'b0);
        step(8'hC1, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h41, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(8'h00, 1'b0, 1'b0, 1'b0);
        chk("s6_after_iex", {24'd0, iex}, 32'd1);
        chk("s6_after_retired", {16'd0, retired}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
